// File: rtl/data_memory_if.sv
// Bus bundle between the core memory stage / program loader and data_memory.
// The slave modport is the memory side; the master modport is the driver side.
interface data_memory_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        rd_wr;
  logic [31:0] rd_data;
  logic        busy;
  logic        err;
  logic [31:0] err_addr;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport slave (
    input  addr, wr_data, rd_wr, load_valid, load_addr, load_data,
    output rd_data, busy, err, err_addr, load_ready
  );

  modport master (
    output addr, wr_data, rd_wr, load_valid, load_addr, load_data,
    input  rd_data, busy, err, err_addr, load_ready
  );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory behind the core's memory stage. After reset it
// zeroes itself with a clear sequencer, then serves CPU loads/stores and loader writes.
module data_memory #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic            rd_sel_q, rd_sel_d;
  logic [31:0]     ram_rd_q;
  logic [31:0]     mem [DEPTH];

  logic            busy, load_ready, load_xfer;
  logic            cpu_legal, load_legal, cpu_err, load_err;
  logic [AW-1:0]   cpu_idx, load_idx;
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;

  // The 32-bit unsigned compare keeps addresses below the base from aliasing.
  function automatic logic legal_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (a[1:0] == 2'b00) && ({2'b00, off[31:2]} < DEPTH);
  endfunction

  function automatic logic [AW-1:0] idx_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  assign cpu_legal  = legal_f(bus.addr);
  assign load_legal = legal_f(bus.load_addr);
  assign cpu_idx    = idx_f(bus.addr);
  assign load_idx   = idx_f(bus.load_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The terminal count is detected explicitly so the counter never starts a second pass.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy       = (state_q == CLEAR);
    load_ready = (state_q == RUN) && bus.rd_wr;
    load_xfer  = bus.load_valid && load_ready;
    cpu_err    = !cpu_legal && (!bus.rd_wr || (bus.addr != 32'd0));
    load_err   = load_xfer && !load_legal;
    mem_we     = 1'b0;
    mem_widx   = cpu_idx;
    mem_wdata  = bus.wr_data;
    rd_sel_d   = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      rd_sel_d = bus.rd_wr && cpu_legal;
      // CPU stores and loader transfers are mutually exclusive through load_ready.
      if (!bus.rd_wr && cpu_legal) begin
        mem_we = 1'b1;
      end else if (load_xfer && load_legal) begin
        mem_we    = 1'b1;
        mem_widx  = load_idx;
        mem_wdata = bus.load_data;
      end
      if (cpu_err || load_err) begin
        err_d = 1'b1;
        if (!err_q) begin
          err_addr_d = cpu_err ? bus.addr : bus.load_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_sel_q   <= 1'b0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  // Single-port style array: the registered read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
    ram_rd_q <= mem[cpu_idx];
  end

  assign bus.rd_data    = rd_sel_q ? ram_rd_q : 32'd0;
  assign bus.busy       = busy;
  assign bus.load_ready = load_ready;
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared each cycle against a behavioural model.
module tb_data_memory;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h8002_0000;

  logic clk = 1'b0;
  logic reset;
  data_memory_if dif();

  data_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   checking = 0;
  logic lr_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, clear countdown and sticky error state.
  logic [31:0] m_mem [DEPTH];
  int          m_clear_left;
  logic [31:0] m_rd;
  logic        m_err;
  logic [31:0] m_err_addr;

  function automatic bit legal(input logic [31:0] a);
    longint unsigned la;
    la = a;
    return (la >= BASE) && (la % 4 == 0) && ((la - BASE) / 4 < DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    longint unsigned la;
    la = a;
    return int'((la - BASE) / 4);
  endfunction

  function automatic void model_reset();
    m_clear_left = DEPTH;
    m_rd         = 32'd0;
    m_err        = 1'b0;
    m_err_addr   = 32'd0;
  endfunction

  function automatic void model_step();
    bit cl, ll, rd, cerr, lx, lerr;
    if (m_clear_left > 0) begin
      m_clear_left--;
      m_rd = 32'd0;
      if (m_clear_left == 0) begin
        foreach (m_mem[i]) m_mem[i] = 32'd0;
      end
    end else begin
      cl   = legal(dif.addr);
      ll   = legal(dif.load_addr);
      rd   = dif.rd_wr;
      cerr = !cl && (!rd || dif.addr != 32'd0);
      lx   = rd && dif.load_valid;
      lerr = lx && !ll;
      m_rd = (rd && cl) ? m_mem[word_of(dif.addr)] : 32'd0;
      if (!rd && cl) m_mem[word_of(dif.addr)] = dif.wr_data;
      if (lx && ll) m_mem[word_of(dif.load_addr)] = dif.load_data;
      if (!m_err) begin
        if (cerr) m_err_addr = dif.addr;
        else if (lerr) m_err_addr = dif.load_addr;
      end
      if (cerr || lerr) m_err = 1'b1;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    wait (checking);
    forever begin
      @(negedge clk);
      check("rd_data",    dif.rd_data,    m_rd);
      check("busy",       32'(dif.busy),  32'(m_clear_left > 0));
      check("err",        32'(dif.err),   32'(m_err));
      check("err_addr",   dif.err_addr,   m_err_addr);
      check("load_ready", 32'(dif.load_ready), 32'((m_clear_left == 0) && dif.rd_wr));
    end
  end

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic rw,
                     input logic lv, input logic [31:0] la, input logic [31:0] ld);
    dif.addr       = a;
    dif.wr_data    = wd;
    dif.rd_wr      = rw;
    dif.load_valid = lv;
    dif.load_addr  = la;
    dif.load_data  = ld;
    #1;
    lr_seen = dif.load_ready;
    @(posedge clk);
    #1;
    $display("cyc t=%0t addr=%h rw=%0b wd=%h lv=%0b la=%h -> rd=%h err=%0b", $time, a, rw, wd, lv, la, dif.rd_data, dif.err);
  endtask

  task automatic idle();
    cyc(32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(a, d, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset pulse starting mid-cycle, outputs checked while it is held.
  task automatic do_reset(input string tag);
    dif.rd_wr = 1'b1;
    dif.load_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check({tag, "_busy"},     32'(dif.busy), 32'd1);
    check({tag, "_rd_data"},  dif.rd_data, 32'd0);
    check({tag, "_err"},      32'(dif.err), 32'd0);
    check({tag, "_err_addr"}, dif.err_addr, 32'd0);
    check({tag, "_lready"},   32'(dif.load_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("reset %s released t=%0t", tag, $time);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    dif.addr = 32'd0;
    dif.rd_wr = 1'b1;
    dif.load_valid = 1'b0;
    while (dif.busy && n < 2 * DEPTH) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_len"}, 32'(n), 32'(DEPTH));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
      2: return BASE - 4 * $urandom_range(1, 4);
      3: return BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      4: return BASE + 4 * $urandom_range(0, DEPTH - 1);
      default: return BASE + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    dif.addr = 32'd0;
    dif.wr_data = 32'd0;
    dif.rd_wr = 1'b1;
    dif.load_valid = 1'b0;
    dif.load_addr = 32'd0;
    dif.load_data = 32'd0;
    @(posedge clk);
    #1;
    checking = 1;
    check("por_busy", 32'(dif.busy), 32'd1);
    check("por_rd_data", dif.rd_data, 32'd0);
    reset = 1'b0;
    wait_clear("por");

    rd(BASE + 32'h10);
    check("read_after_clear", dif.rd_data, 32'd0);
    check("err_idle", 32'(dif.err), 32'd0);

    wr(BASE + 8, 32'hDEAD_BEEF);
    rd(BASE + 8);
    check("read_back", dif.rd_data, 32'hDEAD_BEEF);
    rd(BASE + 4);
    check("neighbour_zero", dif.rd_data, 32'd0);

    cyc(32'd0, 32'd0, 1'b1, 1'b1, BASE, 32'h1111_1111);
    check("lready_idle", 32'(lr_seen), 32'd1);
    cyc(BASE + 12, 32'h3333_3333, 1'b0, 1'b1, BASE + 4, 32'h2222_2222);
    check("lready_cpu_wr", 32'(lr_seen), 32'd0);
    cyc(32'd0, 32'd0, 1'b1, 1'b1, BASE + 4, 32'h2222_2222);
    check("lready_retry", 32'(lr_seen), 32'd1);
    rd(BASE);
    check("load_word0", dif.rd_data, 32'h1111_1111);
    rd(BASE + 4);
    check("load_word1", dif.rd_data, 32'h2222_2222);
    rd(BASE + 12);
    check("cpu_word3", dif.rd_data, 32'h3333_3333);

    rd(BASE + 2);
    check("misalign_err", 32'(dif.err), 32'd1);
    check("misalign_addr", dif.err_addr, BASE + 2);
    check("misalign_rd", dif.rd_data, 32'd0);
    rd(BASE - 4);
    check("below_base_first_only", dif.err_addr, BASE + 2);
    rd(BASE + 8);
    check("no_change", dif.rd_data, 32'hDEAD_BEEF);
    wr(BASE + 4 * DEPTH, 32'h0000_ABCD);
    rd(BASE);
    check("no_alias_word0", dif.rd_data, 32'h1111_1111);

    do_reset("mid_run");
    wait_clear("mid_run");
    rd(BASE + 8);
    check("recleared_8", dif.rd_data, 32'd0);
    rd(BASE);
    check("recleared_0", dif.rd_data, 32'd0);

    wr(BASE + 4 * DEPTH, 32'h0000_ABCD);
    check("past_end_err", 32'(dif.err), 32'd1);
    check("past_end_addr", dif.err_addr, BASE + 4 * DEPTH);
    rd(BASE);
    check("past_end_word0", dif.rd_data, 32'd0);

    wr(BASE + 20, 32'h5555_AAAA);
    do_reset("pre_clear");
    repeat (100) idle();
    do_reset("mid_clear");
    wait_clear("mid_clear");
    rd(BASE + 20);
    check("mid_clear_word5", dif.rd_data, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) begin
        do_reset("rand");
        wait_clear("rand");
      end
      cyc(rand_addr(), $urandom, ($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
